// File: rtl/intra_mode_scheduler_if.sv
// Handshake bundle between intra_mode_scheduler (master) and the reference loader / prediction datapath (slave).
interface intra_mode_scheduler_if #(
    parameter int BLK_W = 8
);
    logic             ref_req;
    logic             ref_ready;
    logic [BLK_W-1:0] blk_idx;
    logic             mode_valid;
    logic             mode_ready;
    logic [5:0]       mode;
    logic             angle_or_planar;
    logic             last_mode;

    modport master (
        output ref_req, blk_idx, mode_valid, mode, angle_or_planar, last_mode,
        input  ref_ready, mode_ready
    );

    modport slave (
        input  ref_req, blk_idx, mode_valid, mode, angle_or_planar, last_mode,
        output ref_ready, mode_ready
    );
endinterface

// File: rtl/intra_mode_scheduler.sv
// Walks a batch of 4x4 blocks: reference load, then planar / (optional DC) / angular modes one per handshake.
// Optional feature macro: INTRA_SCHED_DC_EN issues DC (mode 1) between planar and the first angular mode.
module intra_mode_scheduler #(
    parameter int MODE_FIRST_ANG = 2,
    parameter int MODE_LAST_ANG  = 34,
    parameter int BLK_W          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BLK_W-1:0]      num_blks,
    output logic                  busy,
    output logic                  done,
    intra_mode_scheduler_if.master bus
);

    typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DONE} state_t;

`ifdef INTRA_SCHED_DC_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    localparam logic [5:0] FIRST_ANG = 6'(MODE_FIRST_ANG);
    localparam logic [5:0] LAST_ANG  = 6'(MODE_LAST_ANG);

    state_t           state_q, state_d;
    logic [BLK_W-1:0] num_blks_q, num_blks_d;
    logic [BLK_W-1:0] blk_idx_q, blk_idx_d;
    logic [5:0]       mode_q, mode_d;
    logic             ref_req_q, ref_req_d;
    logic             mode_valid_q, mode_valid_d;
    logic             aop_q, aop_d;
    logic             last_mode_q, last_mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [5:0]       next_mode;
    logic             xfer;
    logic             last_blk;

    assign xfer     = mode_valid_q & bus.mode_ready;
    assign last_blk = (blk_idx_q == (num_blks_q - 1'b1));

    always_comb begin
        next_mode = mode_q + 6'd1;
        if (mode_q == 6'd0) begin
            next_mode = DC_EN ? 6'd1 : FIRST_ANG;
        end else if (mode_q == 6'd1) begin
            next_mode = FIRST_ANG;
        end
    end

    // Outputs are computed one cycle ahead so every handshake signal comes straight from a flop.
    always_comb begin
        state_d      = state_q;
        num_blks_d   = num_blks_q;
        blk_idx_d    = blk_idx_q;
        mode_d       = mode_q;
        ref_req_d    = ref_req_q;
        mode_valid_d = mode_valid_q;
        aop_d        = aop_q;
        last_mode_d  = last_mode_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    num_blks_d = num_blks;
                    blk_idx_d  = '0;
                    if (num_blks == '0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = LOAD;
                        busy_d    = 1'b1;
                        ref_req_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.ref_ready) begin
                    state_d      = ISSUE;
                    ref_req_d    = 1'b0;
                    mode_valid_d = 1'b1;
                    mode_d       = 6'd0;
                    aop_d        = 1'b0;
                    last_mode_d  = (LAST_ANG == 6'd0);
                end
            end
            ISSUE: begin
                if (xfer) begin
                    if (last_mode_q) begin
                        mode_valid_d = 1'b0;
                        mode_d       = 6'd0;
                        aop_d        = 1'b0;
                        last_mode_d  = 1'b0;
                        if (last_blk) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d   = LOAD;
                            blk_idx_d = blk_idx_q + 1'b1;
                            ref_req_d = 1'b1;
                        end
                    end else begin
                        mode_d      = next_mode;
                        aop_d       = (next_mode >= 6'd2);
                        last_mode_d = (next_mode == LAST_ANG);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            num_blks_q   <= '0;
            blk_idx_q    <= '0;
            mode_q       <= 6'd0;
            ref_req_q    <= 1'b0;
            mode_valid_q <= 1'b0;
            aop_q        <= 1'b0;
            last_mode_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_blks_q   <= num_blks_d;
            blk_idx_q    <= blk_idx_d;
            mode_q       <= mode_d;
            ref_req_q    <= ref_req_d;
            mode_valid_q <= mode_valid_d;
            aop_q        <= aop_d;
            last_mode_q  <= last_mode_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.ref_req         = ref_req_q;
    assign bus.blk_idx         = blk_idx_q;
    assign bus.mode_valid      = mode_valid_q;
    assign bus.mode            = mode_q;
    assign bus.angle_or_planar = aop_q;
    assign bus.last_mode       = last_mode_q;
    assign busy                = busy_q;
    assign done                = done_q;

endmodule

// File: tb/tb_intra_mode_scheduler.sv
// Self-checking bench for intra_mode_scheduler: expected transfer list per batch, checked every cycle.
module tb_intra_mode_scheduler;

    localparam int BLK_W      = 8;
    localparam int MODE_FIRST = 2;
    localparam int MODE_LAST  = 34;
`ifdef INTRA_SCHED_DC_EN
    localparam int DC_MODES = 1;
`else
    localparam int DC_MODES = 0;
`endif
    localparam int MODES_PER_BLK = 1 + DC_MODES + (MODE_LAST - MODE_FIRST + 1);

    typedef struct {
        int blk;
        int mode;
        int aop;
        int last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [BLK_W-1:0] num_blks = '0;
    logic             busy;
    logic             done;

    intra_mode_scheduler_if #(.BLK_W(BLK_W)) bus ();

    intra_mode_scheduler #(
        .MODE_FIRST_ANG(MODE_FIRST),
        .MODE_LAST_ANG (MODE_LAST),
        .BLK_W         (BLK_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .num_blks(num_blks),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   failures = 0;
    int   cycle = 0;
    exp_t expQ[$];

    bit   checkEn = 1'b0;
    int   readyMode = 0;
    int   refDelay = 0;
    bit   junkRef = 1'b0;
    int   refWait = 0;

    int   xferCount, refRises, doneCount, firstXfer, lastXfer, doneCycle, startCycle;

    bit   prevStall = 1'b0;
    bit   prevRefReq = 1'b0;
    bit   prevDone = 1'b0;
    int   prevMode, prevAop, prevLast, prevBlk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Model: the whole batch is the ordered list of mode transfers the datapath must see.
    task automatic buildModel(input int n);
        exp_t e;
        expQ.delete();
        for (int b = 0; b < n; b++) begin
            e.blk = b; e.mode = 0; e.aop = 0; e.last = 0;
            expQ.push_back(e);
            if (DC_MODES != 0) begin
                e.mode = 1; e.aop = 0; e.last = 0;
                expQ.push_back(e);
            end
            for (int m = MODE_FIRST; m <= MODE_LAST; m++) begin
                e.mode = m; e.aop = 1; e.last = (m == MODE_LAST) ? 1 : 0;
                expQ.push_back(e);
            end
        end
    endtask

    // Loader / datapath responder: ready pattern and reference latency are set by the stimulus.
    initial begin
        bus.ref_ready  = 1'b0;
        bus.mode_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (readyMode)
                0:       bus.mode_ready = 1'b1;
                1:       bus.mode_ready = ~bus.mode_ready;
                default: bus.mode_ready = 1'($urandom_range(0, 1));
            endcase
            if (bus.ref_req) refWait++;
            else refWait = 0;
            bus.ref_ready = (bus.ref_req && refWait > refDelay) ||
                            (junkRef && !bus.ref_req && $urandom_range(0, 3) == 0);
        end
    end

    // Per-cycle comparison of the DUT against the model queue.
    always @(negedge clk) begin
        exp_t e;
        if (checkEn) begin
            if (bus.ref_req || bus.mode_valid) checkOutput("busy_active", int'(busy), 1);
            if (bus.ref_req) checkOutput("req_valid_exclusive", int'(bus.mode_valid), 0);
            if (bus.ref_req && !prevRefReq) begin
                refRises++;
                if (expQ.size() == 0) checkOutput("ref_req_unexpected", int'(bus.ref_req), 0);
                else checkOutput("ref_blk_idx", int'(bus.blk_idx), expQ[0].blk);
            end
            if (prevStall) begin
                checkOutput("stall_valid", int'(bus.mode_valid), 1);
                checkOutput("stall_mode", int'(bus.mode), prevMode);
                checkOutput("stall_aop", int'(bus.angle_or_planar), prevAop);
                checkOutput("stall_last", int'(bus.last_mode), prevLast);
                checkOutput("stall_blk", int'(bus.blk_idx), prevBlk);
            end
            if (bus.mode_valid && bus.mode_ready) begin
                if (firstXfer < 0) firstXfer = cycle;
                lastXfer = cycle;
                xferCount++;
                if (expQ.size() == 0) begin
                    checkOutput("xfer_unexpected", int'(bus.mode_valid), 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("xfer_mode", int'(bus.mode), e.mode);
                    checkOutput("xfer_aop", int'(bus.angle_or_planar), e.aop);
                    checkOutput("xfer_last", int'(bus.last_mode), e.last);
                    checkOutput("xfer_blk", int'(bus.blk_idx), e.blk);
                end
            end
            if (done) begin
                doneCount++;
                doneCycle = cycle;
                checkOutput("done_pending_modes", expQ.size(), 0);
                checkOutput("done_busy", int'(busy), 0);
                checkOutput("done_single_pulse", int'(prevDone), 0);
            end
            prevStall  = bus.mode_valid && !bus.mode_ready;
            prevMode   = int'(bus.mode);
            prevAop    = int'(bus.angle_or_planar);
            prevLast   = int'(bus.last_mode);
            prevBlk    = int'(bus.blk_idx);
            prevRefReq = bus.ref_req;
            prevDone   = done;
        end else begin
            prevStall  = 1'b0;
            prevRefReq = 1'b0;
            prevDone   = 1'b0;
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ref_req"}, int'(bus.ref_req), 0);
        checkOutput({tag, "_mode_valid"}, int'(bus.mode_valid), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_last_mode"}, int'(bus.last_mode), 0);
        checkOutput({tag, "_aop"}, int'(bus.angle_or_planar), 0);
        checkOutput({tag, "_mode"}, int'(bus.mode), 0);
        checkOutput({tag, "_blk_idx"}, int'(bus.blk_idx), 0);
    endtask

    // Runs one batch to completion (bounded) with the chosen responder behaviour.
    task automatic applyStimulus(input int n, input int rmode, input int rdelay, input bit junk);
        int budget;
        xferCount = 0; refRises = 0; doneCount = 0;
        firstXfer = -1; lastXfer = -1; doneCycle = -1;
        readyMode = rmode; refDelay = rdelay; junkRef = junk;
        buildModel(n);
        budget = 50 + n * (MODES_PER_BLK * 4 + 40);
        @(posedge clk);
        #1;
        num_blks   = BLK_W'(n);
        start      = 1'b1;
        startCycle = cycle;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < budget && doneCount == 0; i++) begin
            @(posedge clk);
            #1;
            start = junk && busy && ($urandom_range(0, 7) == 0);
            if (start) num_blks = BLK_W'($urandom);
        end
        start = 1'b0;
        if (doneCount == 0) checkOutput("done_timeout", doneCount, 1);
        junkRef = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        bit found;
        exp_t e;

        // Reset held two cycles with start asserted.
        rst = 1'b1;
        start = 1'b1;
        num_blks = BLK_W'(5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_reset_busy", int'(busy), 0);
        checkOutput("idle_after_reset_ref_req", int'(bus.ref_req), 0);

        // Pin the model against hand-derived values.
        buildModel(1);
        checkOutput("model_modes_per_blk", expQ.size(), (DC_MODES != 0) ? 35 : 34);
        e = expQ[0];
        checkOutput("model_first_mode", e.mode, 0);
        checkOutput("model_first_aop", e.aop, 0);
        e = expQ[1];
        checkOutput("model_second_mode", e.mode, (DC_MODES != 0) ? 1 : 2);
        e = expQ[expQ.size() - 1];
        checkOutput("model_last_mode", e.mode, 34);
        checkOutput("model_last_flag", e.last, 1);
        expQ.delete();
        checkEn = 1'b1;

        // Single block, always ready: back-to-back modes, done right after mode 34.
        applyStimulus(1, 0, 1, 1'b0);
        checkOutput("s2_xfers", xferCount, (DC_MODES != 0) ? 35 : 34);
        checkOutput("s2_no_bubbles", lastXfer - firstXfer, xferCount - 1);
        checkOutput("s2_done_latency", doneCycle - lastXfer, 1);
        checkOutput("s2_ref_reqs", refRises, 1);
        checkOutput("s2_done_count", doneCount, 1);

        // Three blocks with a toggling ready.
        applyStimulus(3, 1, 0, 1'b0);
        checkOutput("s3_xfers", xferCount, (DC_MODES != 0) ? 105 : 102);
        checkOutput("s3_ref_reqs", refRises, 3);
        checkOutput("s3_done_count", doneCount, 1);

        // Empty batch.
        applyStimulus(0, 0, 0, 1'b0);
        checkOutput("s4_done_latency", doneCycle - startCycle, 1);
        checkOutput("s4_ref_reqs", refRises, 0);
        checkOutput("s4_xfers", xferCount, 0);

        // Spurious start and ref_ready pulses while busy.
        applyStimulus(2, 2, 0, 1'b1);
        checkOutput("s5_xfers", xferCount, 2 * MODES_PER_BLK);
        checkOutput("s5_ref_reqs", refRises, 2);
        checkOutput("s5_done_count", doneCount, 1);

        // A few random batches.
        for (int k = 0; k < 3; k++) begin
            int n;
            n = $urandom_range(1, 4);
            applyStimulus(n, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            checkOutput("rand_xfers", xferCount, n * MODES_PER_BLK);
            checkOutput("rand_ref_reqs", refRises, n);
            checkOutput("rand_done_count", doneCount, 1);
        end

        // Reset while mode 17 is on the bus, then restart.
        buildModel(2);
        readyMode = 2; refDelay = 0;
        @(posedge clk);
        #1;
        num_blks = BLK_W'(2);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (bus.mode_valid && bus.mode == 6'd17) found = 1'b1;
        end
        checkOutput("s6_reached_mode17", int'(found), 1);
        checkEn = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetOutputs("abort");
        rst = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("abort_no_done", int'(done), 0);
        checkEn = 1'b1;
        applyStimulus(1, 0, 0, 1'b0);
        checkOutput("s6_restart_xfers", xferCount, MODES_PER_BLK);
        checkOutput("s6_restart_done", doneCount, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
